// File: rtl/bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_deserializer
// Purpose  : Collects qualified serial bits into a WIDTH-bit parallel word and
//            presents each completed word on a valid/ready port through a
//            one-entry holding register, with sticky overflow reporting.
// Build    : define PARITY_CHK_EN to append one even-parity bit per frame
//            (checked on arrival, reported on par_err alongside the word).
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous reset, active-low
//            d        - serial data bit, sampled only when en=1
//            en       - bit-valid strobe, one bit consumed per edge
//            clr      - synchronous frame restart, also clears ovf
//            q        - assembled parallel word (holding register)
//            q_valid  - q holds an undelivered word
//            q_ready  - consumer accepts q when q_valid & q_ready
//            busy     - partial frame in progress
//            ovf      - sticky: a completed word was dropped
//            par_err  - parity error for the word in q (0 without parity)
// Revision : 1.0 - initial release
// ============================================================================
module bit_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             ovf,
    output logic             par_err
);

    localparam int unsigned      CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

`ifdef PARITY_CHK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [WIDTH-1:0] hold_q,  hold_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;
    logic             perr_q,  perr_d;

    logic [WIDTH-1:0] w_shifted;   // shift register with d inserted
    logic [WIDTH-1:0] w_word;      // word completed on this edge
    logic             w_done;      // final frame bit sampled on this edge
    logic             w_perr_new;  // parity result for the completing word

    // Shift direction decides which end the first bit ends up at.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {sreg_q[WIDTH-2:0], d};
        end else begin : g_lsb_first
            assign w_shifted = {d, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        hold_d     = hold_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        w_done     = 1'b0;
        w_word     = w_shifted;
        w_perr_new = 1'b0;

        // clr has priority over en: the bit on this edge is discarded and a
        // frame completing on this edge is not delivered.
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
            ovf_d   = 1'b0;
        end else if (en) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    sreg_d = w_shifted;
                    if (cnt_q == c_last_bit) begin
`ifdef PARITY_CHK_EN
                        // Data complete; the parity bit still follows.
                        cnt_d   = cnt_q + c_cnt_one;
                        state_d = ST_PAR;
`else
                        cnt_d   = '0;
                        sreg_d  = '0;
                        state_d = ST_IDLE;
                        w_done  = 1'b1;
                        w_word  = w_shifted;
`endif
                    end else begin
                        cnt_d   = cnt_q + c_cnt_one;
                        state_d = ST_SHIFT;
                    end
                end
`ifdef PARITY_CHK_EN
                ST_PAR: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    cnt_d      = '0;
                    sreg_d     = '0;
                    state_d    = ST_IDLE;
                    w_done     = 1'b1;
                    w_word     = sreg_q;
                    w_perr_new = ^{sreg_q, d};
                end
`endif
                default: begin
                    cnt_d   = '0;
                    sreg_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Holding register: load when empty or drained on this same edge,
        // otherwise the completed word is dropped and ovf latches.
        if (w_done && (!valid_q || q_ready)) begin
            hold_d  = w_word;
            valid_d = 1'b1;
            perr_d  = w_perr_new;
        end else if (w_done) begin
            ovf_d = 1'b1;
        end else if (valid_q && q_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    assign q       = hold_q;
    assign q_valid = valid_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;
`ifdef PARITY_CHK_EN
    assign par_err = perr_q & valid_q;
`else
    assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_deserializer
// Purpose  : Self-checking bench for bit_deserializer. Two instances (MSB-first
//            and LSB-first) share the same stimulus; a frame-level reference
//            model predicts both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_deserializer;

    localparam int W = 8;
`ifdef PARITY_CHK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         d       = 1'b0;
    logic         en      = 1'b0;
    logic         clr     = 1'b0;
    logic         q_ready = 1'b0;

    logic [W-1:0] q_a, q_b;
    logic         qv_a, qv_b, busy_a, busy_b, ovf_a, ovf_b, pe_a, pe_b;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
        .q(q_a), .q_valid(qv_a), .q_ready(q_ready),
        .busy(busy_a), .ovf(ovf_a), .par_err(pe_a)
    );

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
        .q(q_b), .q_valid(qv_b), .q_ready(q_ready),
        .busy(busy_b), .ovf(ovf_b), .par_err(pe_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: bits of the frame received so far, plus the
    // expected contents of the holding register.
    bit           frame[$];
    bit [W-1:0]   exp_qa, exp_qb;
    bit           exp_v, exp_ovf, exp_pe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        frame.delete();
        exp_qa  = '0;
        exp_qb  = '0;
        exp_v   = 1'b0;
        exp_ovf = 1'b0;
        exp_pe  = 1'b0;
    endfunction

    function automatic void model_edge();
        bit         complete = 1'b0;
        bit [W-1:0] wa = '0;
        bit [W-1:0] wb = '0;
        bit         p  = 1'b0;
        if (clr) begin
            frame.delete();
            exp_ovf = 1'b0;
        end else if (en) begin
            frame.push_back(d);
            if (frame.size() == FL) begin
                for (int i = 0; i < W; i++) begin
                    wa[W-1-i] = frame[i];
                    wb[i]     = frame[i];
                end
                for (int i = 0; i < FL; i++) p ^= frame[i];
                complete = 1'b1;
                frame.delete();
            end
        end
        if (complete) begin
            if (!exp_v || q_ready) begin
                exp_qa = wa;
                exp_qb = wb;
                exp_v  = 1'b1;
`ifdef PARITY_CHK_EN
                exp_pe = p;
`else
                exp_pe = 1'b0;
`endif
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_v && q_ready) begin
            exp_v = 1'b0;
        end
    endfunction

    task automatic check_all();
        logic exp_busy;
        exp_busy = (frame.size() != 0);
        chk("a.q",       q_a,    exp_qa);
        chk("b.q",       q_b,    exp_qb);
        chk("a.q_valid", qv_a,   exp_v);
        chk("b.q_valid", qv_b,   exp_v);
        chk("a.busy",    busy_a, exp_busy);
        chk("b.busy",    busy_b, exp_busy);
        chk("a.ovf",     ovf_a,  exp_ovf);
        chk("b.ovf",     ovf_b,  exp_ovf);
        chk("a.par_err", pe_a,   exp_pe & exp_v);
        chk("b.par_err", pe_b,   exp_pe & exp_v);
    endtask

    // One clock edge: model follows the edge, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    function automatic bit frame_bit(input logic [W-1:0] w, input int i, input bit pflip);
        if (i < W) return w[W-1-i];
        return (^w) ^ pflip;
    endfunction

    task automatic send_bit(input bit b, input int gap);
        d  = b;
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (gap) begin
            d = 1'($urandom);
            step();
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input bit pflip);
        for (int i = 0; i < FL; i++) send_bit(frame_bit(w, i, pflip), gap);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // 1: MSB-first A5, back-to-back bits, consumer always ready.
        q_ready = 1'b1;
        send_word(8'hA5, 0, 1'b0);
        repeat (3) step();

        // 2: 3C with 3-cycle gaps between bits.
        send_word(8'h3C, 3, 1'b0);
        repeat (2) step();

        // 3: consumer stalled; second word overflows, ovf sticky until clr.
        q_ready = 1'b0;
        send_word(8'h3C, 0, 1'b0);
        send_word(8'hFF, 0, 1'b0);
        repeat (2) step();
        q_ready = 1'b1;
        step();
        q_ready = 1'b0;
        repeat (2) step();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // 4: drain on the same edge as the final bit of the next word.
        send_word(8'h3C, 0, 1'b0);
        for (int i = 0; i < FL - 1; i++) send_bit(frame_bit(8'hFF, i, 1'b0), 0);
        q_ready = 1'b1;
        send_bit(frame_bit(8'hFF, FL - 1, 1'b0), 0);
        q_ready = 1'b0;
        repeat (2) step();

        // 5a: async reset mid-frame with a word held, then 81.
        for (int i = 0; i < 3; i++) send_bit(frame_bit(8'h5A, i, 1'b0), 0);
        async_reset();
        q_ready = 1'b1;
        send_word(8'h81, 0, 1'b0);
        step();
        // 5b: clr after 5 bits discards the partial frame.
        for (int i = 0; i < 5; i++) send_bit(frame_bit(8'hC3, i, 1'b0), 0);
        clr = 1'b1;
        d   = 1'b1;
        en  = 1'b1;
        step();
        clr = 1'b0;
        en  = 1'b0;
        send_word(8'h96, 0, 1'b0);
        step();

`ifdef PARITY_CHK_EN
        // 6: good parity then bad parity; word delivered in both cases.
        send_word(8'hA5, 0, 1'b0);
        step();
        send_word(8'hA5, 0, 1'b1);
        step();
`endif

        // Random traffic: gaps, stalls, occasional clr and async reset.
        for (int c = 0; c < 4000; c++) begin
            d       = 1'($urandom);
            en      = ($urandom_range(0, 99) < 65);
            q_ready = ($urandom_range(0, 99) < 45);
            clr     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end
        en  = 1'b0;
        clr = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Downstream consumer of the single-bit registered data stage (d/en/q flop).
- Collects qualified serial bits into a WIDTH-bit parallel word.
- Presents each completed word on a valid/ready output port through a one-entry holding register, with sticky overflow reporting.
- Feeds the word-level logic that follows the bit-capture stage.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- MSB_FIRST, 1, 1: first received bit lands in q[WIDTH-1]; 0: first received bit lands in q[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- d  input  1  serial data bit, sampled only when en=1.
- en  input  1  bit-valid strobe; one bit consumed per clk edge with en=1.
- clr  input  1  synchronous frame restart; also clears ovf.
- q  output  WIDTH  assembled parallel word (holding register).
- q_valid  output  1  q holds an undelivered word.
- q_ready  input  1  consumer accepts q when q_valid=1 and q_ready=1.
- busy  output  1  partial frame in progress (bit count != 0).
- ovf  output  1  sticky: a completed word was dropped.
- par_err  output  1  parity error flag qualified by q_valid (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous, immediate): shift register=0, bit count=0, FSM=IDLE, q=0, q_valid=0, ovf=0, par_err=0, busy=0. Reset mid-frame discards the partial frame.
- FSM states:
  - IDLE (count 0).
  - SHIFT (0 < count < WIDTH).
  - PAR: exists only with the macro.
- Transitions:
  - IDLE->SHIFT on en.
  - SHIFT->IDLE when the final data bit is sampled (or ->PAR with the macro).
  - PAR->IDLE on the next en.
- en=0 holds all frame state; gaps of any length are legal.
- MSB_FIRST=1 shifts left (new bit into LSB). MSB_FIRST=0 shifts right (new bit into MSB). After WIDTH bits the first bit sits at the documented end.
- Completion edge (final frame bit sampled with en=1):
  - Holding register empty, or drained on this same edge (q_valid & q_ready): q <= completed word, q_valid=1 from the next cycle.
  - Otherwise: word dropped, q and q_valid unchanged, ovf <= 1.
- Handshake:
  - q_valid & q_ready with no simultaneous load: q_valid <= 0 next cycle; q retains its last value.
  - Simultaneous drain and load: q_valid stays 1 and q takes the new word. No bubble, no overflow.
- Latency: q_valid is high in the cycle after the edge that samples the final bit.
- q and q_valid must not change while q_valid=1 and q_ready=0, except through reset.
- clr=1:
  - Count <= 0, shift register <= 0, FSM <= IDLE, ovf <= 0.
  - q, q_valid and par_err are untouched.
  - clr beats en on the same edge: that bit is discarded.
  - clr coinciding with the completion bit: the word is not delivered.
- busy = (FSM != IDLE), registered.
- Bit counter width = $clog2(WIDTH+1). It wraps to 0 at the end of each frame.

Optional Feature:
- Macro PARITY_CHK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, using the PAR state.
  - Completion occurs on the parity bit.
  - par_err loads together with q: 1 if XOR(data bits, parity bit) != 0.
  - The word is still delivered when par_err=1.
- Undefined:
  - Frame is WIDTH bits, PAR state absent.
  - par_err tied to 0.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, q_ready=1; send bits 1,0,1,0,0,1,0,1 with en every cycle -> q=8'hA5, q_valid high for exactly one cycle starting the cycle after the 8th bit edge; busy=0 afterwards.
2. MSB_FIRST=0; send 0x3C as 0,0,1,1,1,1,0,0 with en=0 gaps of 3 cycles between bits -> q=8'h3C; no state advance during the gaps.
3. q_ready=0; send 0x3C, then 0xFF -> q=8'h3C and q_valid=1 held, ovf=1. Then q_ready=1 for one cycle -> q_valid=0, ovf stays 1 until clr.
4. Hold 0x3C with q_ready=0; raise q_ready on the same edge as the final bit of 0xFF -> q_valid stays 1, q becomes 8'hFF, ovf=0.
5. After 3 bits, drive rst=0 between edges -> all outputs 0 immediately. After release, send 0x81 -> q=8'h81. Repeat with clr asserted after 5 bits -> partial frame discarded; the next 8 bits form the word.
6. With PARITY_CHK_EN: send 0xA5 + parity 0 -> q=8'hA5, par_err=0. Send 0xA5 + parity 1 -> par_err=1, word delivered.
